// File: rtl/reg_transfer_controller.sv
`default_nettype none
// ============================================================================
// Module   : reg_transfer_controller
// Purpose  : Accepts single register-transfer commands (NOP, LOAD_IMM, READ,
//            MOVE) over a valid/ready handshake and sequences the register-
//            file accesses they need. It reports each completed command with
//            a one-cycle result_valid pulse and a sticky result/err pair.
// Ports    : clk, reset (async active-low)
//            cmd_valid/cmd_ready, cmd_op, cmd_dst, cmd_src, cmd_imm
//            rf_enable, rf_read, rf_write, rf_select, rf_data_in, rf_data_out
//            result, result_valid, err, busy
// Revision : 1.0 - initial release
// ============================================================================
module reg_transfer_controller #(
    parameter int operand_size        = 8,
    parameter int number_of_registers = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cmd_valid,
    output logic                           cmd_ready,
    input  logic [1:0]                     cmd_op,
    input  logic [number_of_registers-1:0] cmd_dst,
    input  logic [number_of_registers-1:0] cmd_src,
    input  logic [operand_size-1:0]        cmd_imm,
    output logic                           rf_enable,
    output logic                           rf_read,
    output logic                           rf_write,
    output logic [number_of_registers-1:0] rf_select,
    output logic [operand_size-1:0]        rf_data_in,
    input  logic [operand_size-1:0]        rf_data_out,
    output logic [operand_size-1:0]        result,
    output logic                           result_valid,
    output logic                           err,
    output logic                           busy
);

    localparam int IDX_W = number_of_registers;
    localparam int DAT_W = operand_size;

    localparam logic [1:0] c_op_nop  = 2'b00;
    localparam logic [1:0] c_op_load = 2'b01;
    localparam logic [1:0] c_op_read = 2'b10;
    localparam logic [1:0] c_op_move = 2'b11;

    // The index fields are as wide as the register count, so any index at
    // or above the count is addressable on the bus but not in the file.
    localparam logic [IDX_W-1:0] c_nreg = IDX_W'(number_of_registers);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         op_q, op_d;
    logic [IDX_W-1:0]   dst_q, dst_d;
    logic [IDX_W-1:0]   src_q, src_d;
    logic [DAT_W-1:0]   imm_q, imm_d;
    logic [DAT_W-1:0]   temp_q, temp_d;
    logic [DAT_W-1:0]   result_q, result_d;
    logic               err_q, err_d;

    logic               w_dst_bad;
    logic               w_src_bad;

    assign w_dst_bad = (cmd_dst >= c_nreg);
    assign w_src_bad = (cmd_src >= c_nreg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            op_q     <= c_op_nop;
            dst_q    <= '0;
            src_q    <= '0;
            imm_q    <= '0;
            temp_q   <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            dst_q    <= dst_d;
            src_q    <= src_d;
            imm_q    <= imm_d;
            temp_q   <= temp_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    // Next-state logic. result/err are loaded on the edge that enters DONE,
    // so they are visible during DONE and hold until the next completion.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        dst_d    = dst_q;
        src_d    = src_q;
        imm_d    = imm_q;
        temp_d   = temp_q;
        result_d = result_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d  = cmd_op;
                    dst_d = cmd_dst;
                    src_d = cmd_src;
                    imm_d = cmd_imm;
                    case (cmd_op)
                        c_op_load: begin
                            if (w_dst_bad) begin
                                state_d  = ST_DONE;
                                result_d = '0;
                                err_d    = 1'b1;
                            end else begin
                                state_d  = ST_WR;
                            end
                        end
                        c_op_read: begin
                            if (w_src_bad) begin
                                state_d  = ST_DONE;
                                result_d = '0;
                                err_d    = 1'b1;
                            end else begin
                                state_d  = ST_RD;
                            end
                        end
                        c_op_move: begin
                            if (w_src_bad || w_dst_bad) begin
                                state_d  = ST_DONE;
                                result_d = '0;
                                err_d    = 1'b1;
                            end else begin
                                state_d  = ST_RD;
                            end
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end
            end
            ST_RD: begin
                temp_d = rf_data_out;
                if (op_q == c_op_move) begin
                    state_d  = ST_WR;
                end else begin
                    state_d  = ST_DONE;
                    result_d = rf_data_out;
                    err_d    = 1'b0;
                end
            end
            ST_WR: begin
                state_d  = ST_DONE;
                result_d = (op_q == c_op_load) ? imm_q : temp_q;
                err_d    = 1'b0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode only from registered state and latched command fields.
    // cmd_ready is also gated by reset so it stays low while reset is held.
    always_comb begin
        rf_enable  = 1'b0;
        rf_read    = 1'b0;
        rf_write   = 1'b0;
        rf_select  = '0;
        rf_data_in = '0;
        case (state_q)
            ST_RD: begin
                rf_enable = 1'b1;
                rf_read   = 1'b1;
                rf_select = src_q;
            end
            ST_WR: begin
                rf_enable  = 1'b1;
                rf_write   = 1'b1;
                rf_select  = dst_q;
                rf_data_in = (op_q == c_op_load) ? imm_q : temp_q;
            end
            default: begin
            end
        endcase
    end

    assign cmd_ready    = reset && (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign result_valid = (state_q == ST_DONE);
    assign result       = result_q;
    assign err          = err_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_transfer_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_transfer_controller
// Purpose  : Self-checking bench for reg_transfer_controller with a small
//            register-file model on the rf_* bus and a command-level
//            reference model for randomized commands.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_transfer_controller;

    localparam int W = 8;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [N-1:0] cmd_dst;
    logic [N-1:0] cmd_src;
    logic [W-1:0] cmd_imm;
    logic         rf_enable;
    logic         rf_read;
    logic         rf_write;
    logic [N-1:0] rf_select;
    logic [W-1:0] rf_data_in;
    logic [W-1:0] rf_data_out;
    logic [W-1:0] result;
    logic         result_valid;
    logic         err;
    logic         busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_transfer_controller #(
        .operand_size       (W),
        .number_of_registers(N)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_dst     (cmd_dst),
        .cmd_src     (cmd_src),
        .cmd_imm     (cmd_imm),
        .rf_enable   (rf_enable),
        .rf_read     (rf_read),
        .rf_write    (rf_write),
        .rf_select   (rf_select),
        .rf_data_in  (rf_data_in),
        .rf_data_out (rf_data_out),
        .result      (result),
        .result_valid(result_valid),
        .err         (err),
        .busy        (busy)
    );

    // Register file attached to the controller: write on posedge, read data
    // presented on negedge.
    logic [W-1:0] mem [0:N-1] = '{default: '0};
    logic [W-1:0] rf_rd_q = '0;
    assign rf_data_out = rf_rd_q;

    always @(posedge clk) begin
        if (rf_enable && rf_write)
            mem[rf_select[2:0]] <= rf_data_in;
    end
    always @(negedge clk) begin
        rf_rd_q <= mem[rf_select[2:0]];
    end

    // Per-cycle observations after an accepting edge (cycles 1..4).
    logic         o_en   [1:4];
    logic         o_rd   [1:4];
    logic         o_wr   [1:4];
    logic [N-1:0] o_sel  [1:4];
    logic [W-1:0] o_din  [1:4];
    logic         o_rv   [1:4];
    logic [W-1:0] o_res  [1:4];
    logic         o_err  [1:4];
    logic         o_busy [1:4];
    logic         o_rdy  [1:4];
    logic         o_rdy0;

    // Reference state for randomized commands.
    logic [W-1:0] model_rf [0:N-1] = '{default: '0};
    logic [W-1:0] model_res = '0;
    logic         model_err = 1'b0;

    // Drive one command from an idle point (just after a posedge), then
    // record four cycles of outputs while scrambling cmd_* to show they are
    // ignored once the command is in flight.
    task automatic run_cmd(input logic [1:0] op, input logic [N-1:0] dst,
                           input logic [N-1:0] src, input logic [W-1:0] imm);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_dst   = dst;
        cmd_src   = src;
        cmd_imm   = imm;
        o_rdy0    = cmd_ready;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            if (k > 1) begin
                @(posedge clk);
                #1;
            end
            o_en[k]   = rf_enable;
            o_rd[k]   = rf_read;
            o_wr[k]   = rf_write;
            o_sel[k]  = rf_select;
            o_din[k]  = rf_data_in;
            o_rv[k]   = result_valid;
            o_res[k]  = result;
            o_err[k]  = err;
            o_busy[k] = busy;
            o_rdy[k]  = cmd_ready;
            cmd_op    = 2'($urandom);
            cmd_dst   = N'($urandom);
            cmd_src   = N'($urandom);
            cmd_imm   = W'($urandom);
        end
    endtask

    task automatic test_reset();
        reset     = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 2'b10;
        cmd_dst   = 8'd1;
        cmd_src   = 8'd1;
        cmd_imm   = 8'h5A;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({cmd_ready, busy, rf_enable, rf_read, rf_write, rf_select, rf_data_in,
             result, result_valid, err} !== '0) begin
            errors++;
            $display("FAIL reset_state: got ready=%b busy=%b en=%b rd=%b wr=%b sel=%h din=%h res=%h rv=%b err=%b, want all zero",
                     cmd_ready, busy, rf_enable, rf_read, rf_write, rf_select, rf_data_in,
                     result, result_valid, err);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got ready=%b busy=%b, want ready=1 busy=0", cmd_ready, busy);
        end
    endtask

    task automatic test_random();
        logic [1:0]   op;
        logic [N-1:0] dst, src;
        logic [W-1:0] imm, v, e_din, e_res;
        logic         bad, e_err;
        int           lat;
        logic [30:0]  got, exp;
        bit           e_en, e_rd, e_wr, e_rv;
        logic [N-1:0] e_sel;
        for (int n = 0; n < 60; n++) begin
            op  = 2'($urandom);
            dst = ($urandom_range(0, 5) == 0) ? N'($urandom_range(8, 255)) : N'($urandom_range(0, 7));
            src = ($urandom_range(0, 5) == 0) ? N'($urandom_range(8, 255)) : N'($urandom_range(0, 7));
            imm = W'($urandom);
            run_cmd(op, dst, src, imm);

            bad = (op == 2'b01 && dst >= 8) || (op == 2'b10 && src >= 8) ||
                  (op == 2'b11 && (src >= 8 || dst >= 8));
            lat = (op == 2'b00) ? 0 : bad ? 1 : (op == 2'b11) ? 3 : 2;
            v   = (op == 2'b01 || bad) ? imm : model_rf[src[2:0]];

            checks++;
            if (o_rdy0 !== 1'b1) begin
                errors++;
                $display("FAIL rand_ready_before cmd %0d: got %b want 1", n, o_rdy0);
            end

            for (int k = 1; k <= 4; k++) begin
                e_en = 0; e_rd = 0; e_wr = 0; e_sel = '0; e_din = '0; e_rv = 0;
                if (k < lat) begin
                    if (k == 1 && op != 2'b01) begin
                        e_en = 1; e_rd = 1; e_sel = src;
                    end else begin
                        e_en = 1; e_wr = 1; e_sel = dst; e_din = v;
                    end
                end
                if (k == lat) begin
                    e_rv      = 1;
                    model_res = bad ? '0 : v;
                    model_err = bad;
                end
                e_res = model_res;
                e_err = model_err;
                exp = {e_en, e_rd, e_wr, e_sel, e_din, e_rv, e_res, e_err,
                       (k <= lat), !(k <= lat)};
                got = {o_en[k], o_rd[k], o_wr[k], o_sel[k], o_din[k], o_rv[k],
                       o_res[k], o_err[k], o_busy[k], o_rdy[k]};
                checks++;
                if (got !== exp) begin
                    errors++;
                    $display("FAIL rand cmd %0d op=%0d dst=%0d src=%0d cycle %0d: got %h want %h",
                             n, op, dst, src, k, got, exp);
                end
            end
            if (!bad && (op == 2'b01 || op == 2'b11))
                model_rf[dst[2:0]] = v;
        end
    endtask

    task automatic test_load_read();
        run_cmd(2'b01, 8'd3, 8'd0, 8'hA5);
        checks++;
        if ({o_en[1], o_wr[1], o_rd[1], o_sel[1], o_din[1]} !== {1'b1, 1'b1, 1'b0, 8'd3, 8'hA5}) begin
            errors++;
            $display("FAIL load_wr_cycle: got en=%b wr=%b rd=%b sel=%h din=%h want 1 1 0 03 a5",
                     o_en[1], o_wr[1], o_rd[1], o_sel[1], o_din[1]);
        end
        checks++;
        if ({o_rv[2], o_res[2], o_err[2]} !== {1'b1, 8'hA5, 1'b0}) begin
            errors++;
            $display("FAIL load_done: got rv=%b res=%h err=%b want 1 a5 0", o_rv[2], o_res[2], o_err[2]);
        end
        checks++;
        if ({o_rv[3], o_res[3], o_rdy[3]} !== {1'b0, 8'hA5, 1'b1}) begin
            errors++;
            $display("FAIL load_hold: got rv=%b res=%h ready=%b want 0 a5 1", o_rv[3], o_res[3], o_rdy[3]);
        end
        run_cmd(2'b10, 8'd0, 8'd3, 8'h00);
        checks++;
        if ({o_en[1], o_rd[1], o_wr[1], o_sel[1], o_rv[1]} !== {1'b1, 1'b1, 1'b0, 8'd3, 1'b0}) begin
            errors++;
            $display("FAIL read_rd_cycle: got en=%b rd=%b wr=%b sel=%h rv=%b want 1 1 0 03 0",
                     o_en[1], o_rd[1], o_wr[1], o_sel[1], o_rv[1]);
        end
        checks++;
        if ({o_rv[2], o_res[2], o_err[2]} !== {1'b1, 8'hA5, 1'b0}) begin
            errors++;
            $display("FAIL read_done: got rv=%b res=%h err=%b want 1 a5 0", o_rv[2], o_res[2], o_err[2]);
        end
    endtask

    task automatic test_move();
        run_cmd(2'b11, 8'd5, 8'd3, 8'h00);
        checks++;
        if ({o_rd[1], o_wr[1], o_sel[1]} !== {1'b1, 1'b0, 8'd3}) begin
            errors++;
            $display("FAIL move_rd: got rd=%b wr=%b sel=%h want 1 0 03", o_rd[1], o_wr[1], o_sel[1]);
        end
        checks++;
        if ({o_rd[2], o_wr[2], o_sel[2], o_din[2], o_rv[2]} !== {1'b0, 1'b1, 8'd5, 8'hA5, 1'b0}) begin
            errors++;
            $display("FAIL move_wr: got rd=%b wr=%b sel=%h din=%h rv=%b want 0 1 05 a5 0",
                     o_rd[2], o_wr[2], o_sel[2], o_din[2], o_rv[2]);
        end
        checks++;
        if ({o_rv[3], o_res[3], o_err[3]} !== {1'b1, 8'hA5, 1'b0}) begin
            errors++;
            $display("FAIL move_done: got rv=%b res=%h err=%b want 1 a5 0", o_rv[3], o_res[3], o_err[3]);
        end
        run_cmd(2'b10, 8'd0, 8'd5, 8'h00);
        checks++;
        if ({o_rv[2], o_res[2]} !== {1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL move_readback: got rv=%b res=%h want 1 a5", o_rv[2], o_res[2]);
        end
    endtask

    task automatic test_error();
        run_cmd(2'b10, 8'd0, 8'd9, 8'h00);
        checks++;
        if ({o_en[1], o_rd[1], o_wr[1], o_rv[1], o_res[1], o_err[1]} !==
            {1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL err_done: got en=%b rd=%b wr=%b rv=%b res=%h err=%b want 0 0 0 1 00 1",
                     o_en[1], o_rd[1], o_wr[1], o_rv[1], o_res[1], o_err[1]);
        end
        checks++;
        if ({o_rv[2], o_err[2], o_rdy[2]} !== {1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL err_hold: got rv=%b err=%b ready=%b want 0 1 1", o_rv[2], o_err[2], o_rdy[2]);
        end
    endtask

    task automatic test_back_to_back();
        cmd_valid = 1'b1;
        cmd_op    = 2'b00;
        cmd_dst   = 8'd2;
        cmd_src   = 8'd3;
        cmd_imm   = 8'h11;
        @(posedge clk);
        #1;
        checks++;
        if ({cmd_ready, busy, rf_enable, result_valid} !== 4'b1000) begin
            errors++;
            $display("FAIL nop_silent: got ready=%b busy=%b en=%b rv=%b want 1 0 0 0",
                     cmd_ready, busy, rf_enable, result_valid);
        end
        cmd_op = 2'b10;
        @(posedge clk);
        #1;
        checks++;
        if ({cmd_ready, rf_read, rf_select} !== {1'b0, 1'b1, 8'd3}) begin
            errors++;
            $display("FAIL b2b_rd: got ready=%b rd=%b sel=%h want 0 1 03", cmd_ready, rf_read, rf_select);
        end
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({cmd_ready, result_valid, result} !== {1'b0, 1'b1, 8'hA5}) begin
            errors++;
            $display("FAIL b2b_done: got ready=%b rv=%b res=%h want 0 1 a5", cmd_ready, result_valid, result);
        end
        @(posedge clk);
        #1;
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ready_back: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_reset_mid();
        logic saw_rv = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 2'b11;
        cmd_dst   = 8'd6;
        cmd_src   = 8'd3;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({rf_write, rf_enable, rf_select} !== {1'b1, 1'b1, 8'd6}) begin
            errors++;
            $display("FAIL midrst_in_wr: got wr=%b en=%b sel=%h want 1 1 06", rf_write, rf_enable, rf_select);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({rf_write, rf_enable, busy, cmd_ready, result_valid} !== 5'b00000) begin
            errors++;
            $display("FAIL midrst_async: got wr=%b en=%b busy=%b ready=%b rv=%b want all 0",
                     rf_write, rf_enable, busy, cmd_ready, result_valid);
        end
        repeat (2) begin
            @(posedge clk);
            #1;
            saw_rv = saw_rv | result_valid;
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        saw_rv = saw_rv | result_valid;
        checks++;
        if ({saw_rv, busy, cmd_ready} !== 3'b001) begin
            errors++;
            $display("FAIL midrst_after: got rv_seen=%b busy=%b ready=%b want 0 0 1", saw_rv, busy, cmd_ready);
        end
        run_cmd(2'b10, 8'd0, 8'd6, 8'h00);
        checks++;
        if ({o_rv[2], o_res[2]} !== {1'b1, 8'h00}) begin
            errors++;
            $display("FAIL midrst_no_write: got rv=%b res=%h want 1 00", o_rv[2], o_res[2]);
        end
    endtask

    initial begin
        test_reset();
        test_random();
        // Clear register 6 so the aborted MOVE can be shown not to write it.
        run_cmd(2'b01, 8'd6, 8'd0, 8'h00);
        test_load_read();
        test_move();
        test_error();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
